wishbone_arbiter2: RTL and testbench

- Two-master, one-slave Wishbone arbiter placed directly downstream of the CPU's two `wishbone_bus2` interfaces:
  - master 0 is the data-bus instance;
  - master 1 is the instruction-bus instance.
- Grants the shared slave port to one master for a whole bus cycle, using round-robin on ties.
- Routes address, data, select and write-enable to the slave, and routes read data and ack back to the granted master only.
- A watchdog terminates any transfer the slave fails to acknowledge, so the CPU's stall request cannot hang forever.

---
 rtl/wishbone_arbiter2_if.sv | 22 ++
 rtl/wishbone_arbiter2.sv | 150 +++++++++++++++
 tb/tb_wishbone_arbiter2.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_arbiter2_if.sv
// Single Wishbone link: one master, one slave, classic single-cycle handshake.
// The master modport drives the request side, and the slave modport answers it.
interface wishbone_arbiter2_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic        ack;

    modport master (
        output addr, wdata, we, sel, stb, cyc,
        input  rdata, ack
    );

    modport slave (
        input  addr, wdata, we, sel, stb, cyc,
        output rdata, ack
    );
endinterface

// File: rtl/wishbone_arbiter2.sv
// Two-master, one-slave Wishbone arbiter with round-robin tie-break and ack watchdog.
// Master 0 is the CPU data bus and master 1 is the instruction bus.
module wishbone_arbiter2 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    wishbone_arbiter2_if.slave   m0,
    wishbone_arbiter2_if.slave   m1,
    wishbone_arbiter2_if.master  s,
    output logic                 timeout_o,
    output logic [1:0]           grant_o
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    // The abort state remembers its owner so that the terminating ack reaches the right master.
    typedef enum logic [2:0] {
        IDLE,
        GRANT0,
        GRANT1,
        ABORT0,
        ABORT1
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       last, last_nxt;

    logic own_is_m1;
    logic own_cyc;
    logic own_stb;

    assign own_is_m1 = (state == GRANT1) || (state == ABORT1);
    assign own_cyc   = own_is_m1 ? m1.cyc : m0.cyc;
    assign own_stb   = own_is_m1 ? m1.stb : m0.stb;

    // NOTE: reset is sampled on the clock edge only; rst is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        unique case (state)
            IDLE: begin
                cnt_nxt = 8'd0;
                if (m0.cyc && m1.cyc) begin
                    state_nxt = last ? GRANT0 : GRANT1;
                    last_nxt  = ~last;
                end else if (m0.cyc) begin
                    state_nxt = GRANT0;
                end else if (m1.cyc) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (!own_cyc) begin
                    state_nxt = IDLE;
                end else if (s.ack) begin
                    cnt_nxt = 8'd0;
                end else if (own_stb) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = (state == GRANT1) ? ABORT1 : ABORT0;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            ABORT0, ABORT1: begin
                // A zero count marks the first abort cycle; afterwards it is held non-zero.
                cnt_nxt = 8'd1;
                if (!own_cyc) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s.addr    = 32'd0;
        s.wdata   = 32'd0;
        s.we      = 1'b0;
        s.sel     = 4'd0;
        s.stb     = 1'b0;
        s.cyc     = 1'b0;
        m0.rdata  = 32'd0;
        m0.ack    = 1'b0;
        m1.rdata  = 32'd0;
        m1.ack    = 1'b0;
        timeout_o = 1'b0;
        grant_o   = 2'b00;
        unique case (state)
            IDLE: ;
            GRANT0: begin
                s.addr   = m0.addr;
                s.wdata  = m0.wdata;
                s.we     = m0.we;
                s.sel    = m0.sel;
                s.stb    = m0.stb;
                s.cyc    = m0.cyc;
                m0.rdata = s.rdata;
                m0.ack   = s.ack;
                grant_o  = 2'b01;
            end
            GRANT1: begin
                s.addr   = m1.addr;
                s.wdata  = m1.wdata;
                s.we     = m1.we;
                s.sel    = m1.sel;
                s.stb    = m1.stb;
                s.cyc    = m1.cyc;
                m1.rdata = s.rdata;
                m1.ack   = s.ack;
                grant_o  = 2'b10;
            end
            ABORT0: begin
                grant_o = 2'b01;
                if (cnt == 8'd0) begin
                    m0.ack    = 1'b1;
                    m0.rdata  = 32'hFFFF_FFFF;
                    timeout_o = 1'b1;
                end
            end
            ABORT1: begin
                grant_o = 2'b10;
                if (cnt == 8'd0) begin
                    m1.ack    = 1'b1;
                    m1.rdata  = 32'hFFFF_FFFF;
                    timeout_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wishbone_arbiter2.sv
// Directed plus randomized bench for wishbone_arbiter2, checked every cycle against a
// transaction-level model of ownership, watchdog waiting and tie-break preference.
module tb_wishbone_arbiter2;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        timeout_o;
    logic [1:0]  grant_o;

    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic        m_we    [2];
    logic [3:0]  m_sel   [2];
    logic        m_stb   [2];
    logic        m_cyc   [2];
    logic [31:0] s_rdata;
    logic        s_ack;

    wishbone_arbiter2_if m0_bus ();
    wishbone_arbiter2_if m1_bus ();
    wishbone_arbiter2_if s_bus ();

    assign m0_bus.addr  = m_addr[0];
    assign m0_bus.wdata = m_wdata[0];
    assign m0_bus.we    = m_we[0];
    assign m0_bus.sel   = m_sel[0];
    assign m0_bus.stb   = m_stb[0];
    assign m0_bus.cyc   = m_cyc[0];
    assign m1_bus.addr  = m_addr[1];
    assign m1_bus.wdata = m_wdata[1];
    assign m1_bus.we    = m_we[1];
    assign m1_bus.sel   = m_sel[1];
    assign m1_bus.stb   = m_stb[1];
    assign m1_bus.cyc   = m_cyc[1];
    assign s_bus.rdata  = s_rdata;
    assign s_bus.ack    = s_ack;

    wishbone_arbiter2 #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_bus),
        .m1        (m1_bus),
        .s         (s_bus),
        .timeout_o (timeout_o),
        .grant_o   (grant_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc_n  = 0;

    // Reference model: who owns the slave, how many unacknowledged strobe cycles it has
    // waited, whether its cycle is being aborted, and which master the next tie favours.
    int owner       = -1;
    int waited      = 0;
    bit aborting    = 1'b0;
    bit abort_fresh = 1'b0;
    bit tie_to_m1   = 1'b0;
    bit model_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc_n, obs, exp);
    endtask

    task automatic compare_model();
        logic [31:0] e_addr, e_wdata, e_d0, e_d1;
        logic [3:0]  e_sel;
        logic        e_we, e_stb, e_cyc, e_a0, e_a1, e_to;
        logic [1:0]  e_gnt;
        {e_addr, e_wdata, e_d0, e_d1} = '0;
        e_sel = '0;
        {e_we, e_stb, e_cyc, e_a0, e_a1, e_to} = '0;
        e_gnt = 2'b00;
        if (owner >= 0) begin
            e_gnt = (owner == 1) ? 2'b10 : 2'b01;
            if (!aborting) begin
                e_addr  = m_addr[owner];
                e_wdata = m_wdata[owner];
                e_we    = m_we[owner];
                e_sel   = m_sel[owner];
                e_stb   = m_stb[owner];
                e_cyc   = m_cyc[owner];
                if (owner == 0) begin e_a0 = s_ack; e_d0 = s_rdata; end
                else            begin e_a1 = s_ack; e_d1 = s_rdata; end
            end else if (abort_fresh) begin
                e_to = 1'b1;
                if (owner == 0) begin e_a0 = 1'b1; e_d0 = 32'hFFFF_FFFF; end
                else            begin e_a1 = 1'b1; e_d1 = 32'hFFFF_FFFF; end
            end
        end
        check("model_grant",   32'(grant_o),      32'(e_gnt));
        check("model_timeout", 32'(timeout_o),    32'(e_to));
        check("model_s_addr",  s_bus.addr,        e_addr);
        check("model_s_data",  s_bus.wdata,       e_wdata);
        check("model_s_we",    32'(s_bus.we),     32'(e_we));
        check("model_s_sel",   32'(s_bus.sel),    32'(e_sel));
        check("model_s_stb",   32'(s_bus.stb),    32'(e_stb));
        check("model_s_cyc",   32'(s_bus.cyc),    32'(e_cyc));
        check("model_m0_ack",  32'(m0_bus.ack),   32'(e_a0));
        check("model_m0_data", m0_bus.rdata,      e_d0);
        check("model_m1_ack",  32'(m1_bus.ack),   32'(e_a1));
        check("model_m1_data", m1_bus.rdata,      e_d1);
    endtask

    task automatic model_step();
        if (!rst) begin
            owner       = -1;
            waited      = 0;
            aborting    = 1'b0;
            abort_fresh = 1'b0;
            tie_to_m1   = 1'b0;
            model_valid = 1'b1;
        end else if (owner < 0) begin
            waited = 0;
            if (m_cyc[0] && m_cyc[1]) begin
                owner     = tie_to_m1 ? 1 : 0;
                tie_to_m1 = (owner == 0);
            end else if (m_cyc[0]) begin
                owner = 0;
            end else if (m_cyc[1]) begin
                owner = 1;
            end
        end else if (aborting) begin
            abort_fresh = 1'b0;
            if (!m_cyc[owner]) begin
                owner    = -1;
                aborting = 1'b0;
            end
        end else if (!m_cyc[owner]) begin
            owner = -1;
        end else if (s_ack) begin
            waited = 0;
        end else if (m_stb[owner]) begin
            waited++;
            if (waited == TO) begin
                aborting    = 1'b1;
                abort_fresh = 1'b1;
                waited      = 0;
            end
        end
    endtask

    // One clock: inputs were set after the falling edge; compare, take the edge, advance the model.
    task automatic tick();
        #1;
        if (model_valid) compare_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic req(input int m, input logic on);
        m_cyc[m] = on;
        m_stb[m] = on;
    endtask

    initial begin
        rst     = 1'b0;
        s_ack   = 1'b0;
        s_rdata = 32'd0;
        for (int m = 0; m < 2; m++) begin
            m_addr[m]  = 32'd0;
            m_wdata[m] = 32'd0;
            m_we[m]    = 1'b0;
            m_sel[m]   = 4'd0;
            req(m, 1'b0);
        end
        @(negedge clk);

        // Reset state
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_grant",   32'(grant_o),   32'd0);
        check("rst_s_cyc",   32'(s_bus.cyc), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);

        // m0 read, slave acks on the third granted cycle
        m_addr[0] = 32'h0000_0010;
        m_sel[0]  = 4'hF;
        req(0, 1'b1);
        tick();
        #1;
        check("rd_grant", 32'(grant_o),   32'h1);
        check("rd_stb",   32'(s_bus.stb), 32'h1);
        check("rd_addr",  s_bus.addr,     32'h0000_0010);
        tick();
        tick();
        s_ack   = 1'b1;
        s_rdata = 32'h1234_5678;
        #1;
        check("rd_m0_ack",  32'(m0_bus.ack), 32'h1);
        check("rd_m0_data", m0_bus.rdata,    32'h1234_5678);
        check("rd_m1_ack",  32'(m1_bus.ack), 32'h0);
        tick();
        s_ack = 1'b0;
        req(0, 1'b0);
        tick();
        #1;
        check("rd_release", 32'(grant_o), 32'h0);
        tick();

        // Both masters keep requesting: grants alternate with one idle cycle between
        req(0, 1'b1);
        req(1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("tie_gap", 32'(grant_o), 32'h0);
            tick();
            #1;
            check("tie_owner", 32'(grant_o), (k % 2 == 1) ? 32'h2 : 32'h1);
            s_ack = 1'b1;
            tick();
            s_ack = 1'b0;
            req(k % 2, 1'b0);
            tick();
            req(k % 2, 1'b1);
        end
        req(0, 1'b0);
        req(1, 1'b0);
        tick();

        // m1 write while m0 requests mid-cycle
        m_addr[1]  = 32'h2000_0040;
        m_wdata[1] = 32'hCAFE_BABE;
        m_sel[1]   = 4'b0011;
        m_we[1]    = 1'b1;
        req(1, 1'b1);
        tick();
        #1;
        check("wr_grant", 32'(grant_o), 32'h2);
        tick();
        m_addr[0]  = 32'h3000_0000;
        m_wdata[0] = 32'h1111_1111;
        m_sel[0]   = 4'hF;
        req(0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            s_ack = (i == 2);
            #1;
            check("wr_addr",   s_bus.addr,          32'h2000_0040);
            check("wr_data",   s_bus.wdata,         32'hCAFE_BABE);
            check("wr_sel",    32'(s_bus.sel),      32'h3);
            check("wr_we",     32'(s_bus.we),       32'h1);
            check("wr_m0_ack", 32'(m0_bus.ack),     32'h0);
            check("wr_m1_ack", 32'(m1_bus.ack),     (i == 2) ? 32'h1 : 32'h0);
            tick();
        end
        s_ack = 1'b0;
        req(1, 1'b0);
        m_we[1] = 1'b0;
        tick();
        #1;
        check("wr_gap", 32'(grant_o), 32'h0);
        tick();
        #1;
        check("wr_m0_next", 32'(grant_o), 32'h1);
        check("wr_m0_addr", s_bus.addr,   32'h3000_0000);
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        req(0, 1'b0);
        tick();
        tick();

        // Slave never acks: watchdog aborts after TO strobe cycles
        m_addr[0] = 32'h0000_0040;
        req(0, 1'b1);
        tick();
        for (int i = 0; i < TO; i++) begin
            #1;
            check("wd_stb",     32'(s_bus.stb), 32'h1);
            check("wd_no_fire", 32'(timeout_o), 32'h0);
            tick();
        end
        s_ack = 1'b1;
        #1;
        check("wd_ack",     32'(m0_bus.ack), 32'h1);
        check("wd_data",    m0_bus.rdata,    32'hFFFF_FFFF);
        check("wd_timeout", 32'(timeout_o),  32'h1);
        check("wd_s_cyc",   32'(s_bus.cyc),  32'h0);
        check("wd_s_stb",   32'(s_bus.stb),  32'h0);
        tick();
        #1;
        check("wd_hold_ack",     32'(m0_bus.ack), 32'h0);
        check("wd_hold_timeout", 32'(timeout_o),  32'h0);
        tick();
        s_ack = 1'b0;
        req(0, 1'b0);
        tick();
        #1;
        check("wd_idle", 32'(grant_o), 32'h0);
        tick();

        // cyc drop at the threshold cycle beats the watchdog
        req(0, 1'b1);
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        req(0, 1'b0);
        #1;
        check("race_drop_timeout", 32'(timeout_o), 32'h0);
        tick();
        #1;
        check("race_drop_idle",    32'(grant_o),   32'h0);
        check("race_drop_no_fire", 32'(timeout_o), 32'h0);
        tick();

        // ack at the threshold cycle completes the transfer normally
        req(0, 1'b1);
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        s_ack   = 1'b1;
        s_rdata = 32'hA5A5_5A5A;
        #1;
        check("race_ack_ack",  32'(m0_bus.ack), 32'h1);
        check("race_ack_data", m0_bus.rdata,    32'hA5A5_5A5A);
        tick();
        s_ack = 1'b0;
        #1;
        check("race_ack_grant",   32'(grant_o),   32'h1);
        check("race_ack_timeout", 32'(timeout_o), 32'h0);
        tick();
        req(0, 1'b0);
        tick();
        tick();

        // m1 flushes two cycles into a pending transfer
        req(1, 1'b1);
        tick();
        tick();
        tick();
        req(1, 1'b0);
        #1;
        check("flush_stb", 32'(s_bus.stb),  32'h0);
        check("flush_ack", 32'(m1_bus.ack), 32'h0);
        tick();
        #1;
        check("flush_idle", 32'(grant_o), 32'h0);
        tick();

        // Reset mid-transfer, then the first tie goes to m0 again
        req(0, 1'b1);
        req(1, 1'b1);
        tick();
        #1;
        check("mid_rst_grant", 32'(grant_o),   32'h1);
        check("mid_rst_stb",   32'(s_bus.stb), 32'h1);
        rst = 1'b0;
        tick();
        #1;
        check("mid_rst_grant0", 32'(grant_o),    32'h0);
        check("mid_rst_stb0",   32'(s_bus.stb),  32'h0);
        check("mid_rst_cyc0",   32'(s_bus.cyc),  32'h0);
        check("mid_rst_ack0",   32'(m0_bus.ack), 32'h0);
        check("mid_rst_to0",    32'(timeout_o),  32'h0);
        tick();
        rst = 1'b1;
        tick();
        #1;
        check("post_rst_tie", 32'(grant_o), 32'h1);
        req(0, 1'b0);
        req(1, 1'b0);
        tick();
        tick();

        // Randomized traffic: segments with different slave ack rates, occasional resets
        for (int seg = 0; seg < 40; seg++) begin
            int rate;
            rate = int'($urandom_range(0, 3));
            for (int c = 0; c < 50; c++) begin
                rst = ($urandom_range(0, 299) != 0);
                for (int m = 0; m < 2; m++) begin
                    if (m_cyc[m]) begin
                        if ($urandom_range(0, 7) == 0) m_cyc[m] = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        m_cyc[m] = 1'b1;
                    end
                    m_stb[m]   = m_cyc[m] && ($urandom_range(0, 7) != 0);
                    m_addr[m]  = $urandom;
                    m_wdata[m] = $urandom;
                    m_we[m]    = 1'($urandom_range(0, 1));
                    m_sel[m]   = 4'($urandom_range(0, 15));
                end
                s_ack   = (int'($urandom_range(0, 7)) < rate * 2);
                s_rdata = $urandom;
                tick();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
